mon_sopc_leds: RTL and testbench
================================

# mon_sopc_leds

Avalon-MM slave output PIO driving the board LEDs from the Nios II bus: the write-side counterpart of the button input PIO in the same SOPC. Holds an output data register with atomic set/clear aliases. An optional per-bit hardware blink engine lets firmware flash LEDs without polling. Sits on the system interconnect next to the button PIO, with `out_port` routed to the LED pins.

## Interface
Parameters:
- `WIDTH`, 8: number of LED outputs (1..32).
- `RESET_VALUE`, 0: value loaded into the data register on reset.
- `PERIOD_W`, 24: width of the blink period register and counter.
- `DEFAULT_PERIOD`, 12499999: reset value of the blink period (0.25 s half-period at 50 MHz).

Ports:
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `address` in 3: word address of the register.
- `chipselect` in 1: slave selected.
- `write_n` in 1: active-low write strobe; a write occurs when `chipselect`=1 and `write_n`=0.
- `writedata` in 32: write data.
- `readdata` out 32: registered read data.
- `out_port` out WIDTH: LED drive.

## Operation
Register map (word addresses; bits above WIDTH read 0, writes to them are ignored):
- 0 `data`, R/W: the LED state.
- 1 `blink_mask`, R/W: 1 = the bit blinks.
- 2 `blink_period`, R/W, PERIOD_W bits: half-period minus one, in clocks.
- 4 `outset`, W: `data <= data | writedata`. Reads return 0.
- 5 `outclear`, W: `data <= data & ~writedata`. Reads return 0.
- 3, 6, 7: read 0; writes ignored.

Reads:
- `readdata` is loaded every cycle from the address mux, regardless of `chipselect`.
- Zero-extended to 32 bits.

Blink engine:
- `cnt` is a PERIOD_W-bit counter; `phase` is one bit.
- Each cycle: if `cnt == blink_period`, then `cnt <= 0` and `phase <= ~phase`; otherwise `cnt <= cnt + 1`.
- With period N, `phase` toggles every N+1 cycles. N=0 toggles every cycle.
- A write to `blink_period` loads the new value, forces `cnt <= 0` and forces `phase <= 1`, so there is no long first half-period after shrinking.
- Output: `out_port[i] = data[i] & (~blink_mask[i] | phase)`. Blinking bits are lit while `phase`=1 and only if their `data` bit is 1.
- `out_port` is combinational from registers only; no path from bus inputs.

## Timing
Reset (synchronous, `reset`=1 at a rising edge):
- `data` = RESET_VALUE
- `blink_mask` = 0
- `blink_period` = DEFAULT_PERIOD
- `cnt` = 0
- `phase` = 1
- `readdata` = 0
- Hence `out_port` = RESET_VALUE[WIDTH-1:0].

Bus timing:
- Reset asserted during a bus write: reset wins and the write is discarded.
- Write: the register updates at the edge where the write is sampled; `out_port` reflects it from that edge on. Zero wait states.
- Read latency: 1 cycle. `readdata` at edge k+1 reflects `address` at edge k and register contents before any write at edge k.
- A read and a write to the same address in the same cycle returns the old value.

Blink timing:
- A `blink_mask`/`data` write takes effect immediately at the current `phase`; the counter is not disturbed.
- A write to `blink_period` at the edge where the counter would have wrapped: the write wins (`cnt`=0, `phase`=1, no toggle).

## Configuration
- `LEDS_BLINK_EN` defined: the blink engine, `blink_mask` and `blink_period` registers, and the counter are compiled in as described above.
- `LEDS_BLINK_EN` undefined:
  - Addresses 1 and 2 behave as unmapped (read 0, writes ignored).
  - No counter.
  - `out_port = data`.
  - The `data`, `outset` and `outclear` behaviour is unchanged.

## Test plan
- Reset with RESET_VALUE=8'hA5 → `out_port`=8'hA5, `readdata`=0. Read address 2 → 12499999 one cycle later.
- Write 0x3C to address 0, then 0x03 to address 4, then 0x14 to address 5 → `out_port` sequence 0x3C, 0x3F, 0x2B. Reads of addresses 4/5 return 0.
- Write 0xFFFFFF0F to address 0 with WIDTH=8 → readback 0x0000000F.
- (`LEDS_BLINK_EN`) Write `data`=0xFF, `blink_mask`=0x0F, `blink_period`=3 → `out_port` alternates 0xFF for 4 cycles then 0xF0 for 4 cycles, starting at 0xFF right after the period write.
- (`LEDS_BLINK_EN`) Period=9; rewrite period=2 at cnt=7 → `phase` forced to 1 and next toggle 3 cycles later. A write coincident with the wrap → no toggle that cycle.
- Assert `reset` during a write of 0x55 to address 0 while blinking → all registers take reset values, write lost, `out_port`=RESET_VALUE. Without the macro, a write to address 1 does not change any output.

Source files
------------

// File: rtl/mon_sopc_leds.sv
// rtl/mon_sopc_leds.sv - Avalon-MM LED output PIO with set/clear aliases.
// Optional per-bit blink engine is compiled in when LEDS_BLINK_EN is defined.
module mon_sopc_leds #(
    parameter int unsigned WIDTH          = 8,
    parameter logic [31:0] RESET_VALUE    = 32'h0,
    parameter int unsigned PERIOD_W       = 24,
    parameter logic [31:0] DEFAULT_PERIOD = 32'd12499999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_MASK   = 3'd1;
    localparam logic [2:0] ADDR_PERIOD = 3'd2;
    localparam logic [2:0] ADDR_SET    = 3'd4;
    localparam logic [2:0] ADDR_CLR    = 3'd5;

    localparam logic [WIDTH-1:0] LP_DATA_RST = RESET_VALUE[WIDTH-1:0];

    logic             w_wr;
    logic [WIDTH-1:0] w_wdata;
    logic [31:0]      w_rd_mux;
    logic [WIDTH-1:0] r_data;

    assign w_wr    = chipselect & ~write_n;
    assign w_wdata = writedata[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= LP_DATA_RST;
        end else if (w_wr) begin
            case (address)
                ADDR_DATA: r_data <= w_wdata;
                ADDR_SET:  r_data <= r_data | w_wdata;
                ADDR_CLR:  r_data <= r_data & ~w_wdata;
                default:   r_data <= r_data;
            endcase
        end
    end

`ifdef LEDS_BLINK_EN
    localparam logic [PERIOD_W-1:0] LP_PERIOD_RST = DEFAULT_PERIOD[PERIOD_W-1:0];

    logic [WIDTH-1:0]    r_mask;
    logic [PERIOD_W-1:0] r_period;
    logic [PERIOD_W-1:0] r_cnt;
    logic                r_phase;
    logic                w_period_wr;

    assign w_period_wr = w_wr && (address == ADDR_PERIOD);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= '0;
        end else if (w_wr && (address == ADDR_MASK)) begin
            r_mask <= w_wdata;
        end
    end

    // A period write restarts the lit half-period so a shrink never waits out the old count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_period <= LP_PERIOD_RST;
            r_cnt    <= '0;
            r_phase  <= 1'b1;
        end else if (w_period_wr) begin
            r_period <= writedata[PERIOD_W-1:0];
            r_cnt    <= '0;
            r_phase  <= 1'b1;
        end else if (r_cnt == r_period) begin
            r_cnt    <= '0;
            r_phase  <= ~r_phase;
        end else begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign out_port = r_data & (~r_mask | {WIDTH{r_phase}});
`else
    assign out_port = r_data;
`endif

    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA:   w_rd_mux[WIDTH-1:0] = r_data;
`ifdef LEDS_BLINK_EN
            ADDR_MASK:   w_rd_mux[WIDTH-1:0] = r_mask;
            ADDR_PERIOD: w_rd_mux[PERIOD_W-1:0] = r_period;
`endif
            default:     w_rd_mux = '0;
        endcase
    end

    // Read data is captured every cycle; chipselect only qualifies writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= w_rd_mux;
        end
    end

    logic w_unused;
    assign w_unused = ^{writedata, RESET_VALUE, DEFAULT_PERIOD, 32'(PERIOD_W)};

endmodule

// File: tb/tb_mon_sopc_leds.sv
// tb/tb_mon_sopc_leds.sv - table-driven bench for mon_sopc_leds (WIDTH=8, RESET_VALUE=8'hA5).
module tb_mon_sopc_leds;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mon_sopc_leds #(
        .WIDTH(8),
        .RESET_VALUE(32'h000000A5),
        .PERIOD_W(24),
        .DEFAULT_PERIOD(32'd12499999)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .out_port(out_port)
    );

    typedef struct {
        logic        cs;
        logic        wn;
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [7:0]  exp_out;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'h0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cycle(1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [2:0] a);
        cycle(1'b1, 1'b1, a, 32'h0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b1, 3'd0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 3'd0, 32'h0,        8'hA5, 32'h000000A5};
        vecs[1]  = '{1'b1, 1'b0, 3'd0, 32'h3C,       8'h3C, 32'h000000A5};
        vecs[2]  = '{1'b1, 1'b0, 3'd4, 32'h03,       8'h3F, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 3'd5, 32'h14,       8'h2B, 32'h0};
        vecs[4]  = '{1'b1, 1'b1, 3'd0, 32'h0,        8'h2B, 32'h0000002B};
        vecs[5]  = '{1'b1, 1'b1, 3'd4, 32'h0,        8'h2B, 32'h0};
        vecs[6]  = '{1'b1, 1'b1, 3'd5, 32'h0,        8'h2B, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 3'd0, 32'hFFFFFF0F, 8'h0F, 32'h0000002B};
        vecs[8]  = '{1'b1, 1'b1, 3'd0, 32'h0,        8'h0F, 32'h0000000F};
        vecs[9]  = '{1'b0, 1'b0, 3'd0, 32'h0,        8'h0F, 32'h0000000F};
        vecs[10] = '{1'b1, 1'b0, 3'd3, 32'hFF,       8'h0F, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 3'd6, 32'hFF,       8'h0F, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 3'd7, 32'hFF,       8'h0F, 32'h0};
        vecs[13] = '{1'b1, 1'b1, 3'd3, 32'h0,        8'h0F, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 3'd4, 32'hFFFFFF00, 8'h0F, 32'h0};
        vecs[15] = '{1'b1, 1'b0, 3'd5, 32'h0000000F, 8'h00, 32'h0};
        vecs[16] = '{1'b1, 1'b0, 3'd4, 32'h81,       8'h81, 32'h0};
        vecs[17] = '{1'b1, 1'b1, 3'd0, 32'h0,        8'h81, 32'h00000081};

        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'h0;
        idle();
        idle();
        check("reset out_port", {24'h0, out_port}, 32'hA5);
        check("reset readdata", readdata, 32'h0);
        reset = 1'b0;

        rd(3'd2);
`ifdef LEDS_BLINK_EN
        check("reset period readback", readdata, 32'd12499999);
`else
        check("unmapped addr2 readback", readdata, 32'h0);
`endif
        check("out after reset release", {24'h0, out_port}, 32'hA5);

        for (int i = 0; i < 18; i++) begin
            cycle(vecs[i].cs, vecs[i].wn, vecs[i].addr, vecs[i].wd);
            check($sformatf("vec%0d out_port", i), {24'h0, out_port}, {24'h0, vecs[i].exp_out});
            check($sformatf("vec%0d readdata", i), readdata, vecs[i].exp_rd);
        end

`ifdef LEDS_BLINK_EN
        wr(3'd0, 32'hFF);
        check("blink data write", {24'h0, out_port}, 32'hFF);
        wr(3'd1, 32'h0F);
        check("blink mask write", {24'h0, out_port}, 32'hFF);
        wr(3'd2, 32'd3);
        check("period3 k0", {24'h0, out_port}, 32'hFF);
        for (int k = 1; k < 16; k++) begin
            idle();
            check($sformatf("period3 k%0d", k), {24'h0, out_port},
                  (((k / 4) % 2) != 0) ? 32'hF0 : 32'hFF);
        end
        rd(3'd1);
        check("mask readback", readdata, 32'h0F);
        rd(3'd2);
        check("period readback", readdata, 32'd3);

        wr(3'd2, 32'd9);
        check("period9 start", {24'h0, out_port}, 32'hFF);
        for (int k = 1; k < 18; k++) begin
            idle();
            check($sformatf("period9 k%0d", k), {24'h0, out_port},
                  (k < 10) ? 32'hFF : 32'hF0);
        end
        wr(3'd2, 32'd2);
        check("shrink forces phase", {24'h0, out_port}, 32'hFF);
        idle();
        check("shrink +1", {24'h0, out_port}, 32'hFF);
        idle();
        check("shrink +2", {24'h0, out_port}, 32'hFF);
        wr(3'd2, 32'd2);
        check("write at wrap no toggle", {24'h0, out_port}, 32'hFF);
        idle();
        check("after wrap write +1", {24'h0, out_port}, 32'hFF);
        idle();
        check("after wrap write +2", {24'h0, out_port}, 32'hFF);
        idle();
        check("after wrap write toggle", {24'h0, out_port}, 32'hF0);

        wr(3'd2, 32'd0);
        check("period0 start", {24'h0, out_port}, 32'hFF);
        idle();
        check("period0 +1", {24'h0, out_port}, 32'hF0);
        idle();
        check("period0 +2", {24'h0, out_port}, 32'hFF);
        idle();
        check("period0 +3", {24'h0, out_port}, 32'hF0);
`else
        wr(3'd1, 32'hFF);
        check("unmapped addr1 write", {24'h0, out_port}, 32'h81);
        wr(3'd2, 32'h1);
        check("unmapped addr2 write", {24'h0, out_port}, 32'h81);
        for (int k = 0; k < 6; k++) begin
            idle();
            check($sformatf("no blink k%0d", k), {24'h0, out_port}, 32'h81);
        end
        rd(3'd1);
        check("unmapped addr1 read", readdata, 32'h0);
        rd(3'd2);
        check("unmapped addr2 read", readdata, 32'h0);
`endif

        reset = 1'b1;
        wr(3'd0, 32'h55);
        reset = 1'b0;
        check("reset beats write out", {24'h0, out_port}, 32'hA5);
        check("reset beats write rd", readdata, 32'h0);
        rd(3'd0);
        check("data after reset", readdata, 32'hA5);
`ifdef LEDS_BLINK_EN
        rd(3'd1);
        check("mask after reset", readdata, 32'h0);
        rd(3'd2);
        check("period after reset", readdata, 32'd12499999);
`endif
        for (int k = 0; k < 4; k++) begin
            idle();
            check($sformatf("post reset k%0d", k), {24'h0, out_port}, 32'hA5);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
